// File: rtl/not_gate_bist_ctrl.sv
// not_gate_bist_ctrl
//   BIST sequencer for a single inverter cell. A start request walks the
//   inverter input through A=0 then A=1. Each vector is held SETTLE_CYCLES
//   cycles, and Z is sampled on the last cycle against the ideal ~A. The
//   result is a 2-bit stuck-at verdict that comes with a one-cycle done pulse.
//
// Parameters
//   SETTLE_CYCLES  hold time per vector before Z is sampled (1..255)
//   CNT_W          width of run_count / fail_count
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   start, abort   run request (taken only in IDLE), cancel of a run in progress
//   uut_a, uut_z   registered drive to the inverter input, inverter output
//   busy, done     not-IDLE flag, one-cycle completion pulse
//   verdict        {vector-1 mismatch, vector-0 mismatch}, held between runs
//   verdict_valid  set by the first completed run
//   run_count      completed runs, saturating
//   fail_count     runs with a nonzero verdict, saturating
//
// Build option
//   NOT_BIST_FAILCNT_EN  builds the fail counter; otherwise fail_count is 0
module not_gate_bist_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             uut_a,
  input  logic             uut_z,
  output logic             busy,
  output logic             done,
  output logic [1:0]       verdict,
  output logic             verdict_valid,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] fail_count
);

  typedef enum logic [1:0] {IDLE, APPLY0, APPLY1, REPORT} state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       mis0, mis0_nxt;
  logic       rpt_load;   // APPLY1 -> REPORT: latch the verdict and count the run
  logic [1:0] verdict_new;

  // Vector 1 expects Z=0. Its mismatch is folded straight into the verdict,
  // so it does not need a register of its own.
  assign verdict_new = {uut_z != 1'b0, mis0};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mis0_nxt  = mis0;
    rpt_load  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = APPLY0;
          cnt_nxt   = SETTLE_LD;
        end
      end
      APPLY0: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == 8'd0) begin
          mis0_nxt  = (uut_z != 1'b1);
          cnt_nxt   = SETTLE_LD;
          state_nxt = APPLY1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      APPLY1: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == 8'd0) begin
          rpt_load  = 1'b1;
          state_nxt = REPORT;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      REPORT: state_nxt = IDLE;   // abort is ignored here
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == REPORT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      mis0          <= 1'b0;
      uut_a         <= 1'b0;
      verdict       <= 2'b00;
      verdict_valid <= 1'b0;
      run_count     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mis0  <= mis0_nxt;
      // uut_a is driven from the next state, so A=1 lines up exactly with
      // the APPLY1 cycles and is a clean flop output toward the cell.
      uut_a <= (state_nxt == APPLY1);
      if (rpt_load) begin
        verdict       <= verdict_new;
        verdict_valid <= 1'b1;
        if (!(&run_count)) run_count <= run_count + CNT_W'(1);
      end
    end
  end

`ifdef NOT_BIST_FAILCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_count <= '0;
    end else if (rpt_load && (verdict_new != 2'b00) && !(&fail_count)) begin
      fail_count <= fail_count + CNT_W'(1);
    end
  end
`else
  assign fail_count = '0;
`endif

endmodule

// File: tb/tb_not_gate_bist_ctrl.sv
module tb_not_gate_bist_ctrl;

  localparam int S = 4;
  localparam int W = 8;

  logic         clk, rst_n, start, abort;
  logic         uut_a, uut_z, busy, done, verdict_valid;
  logic [1:0]   verdict;
  logic [W-1:0] run_count, fail_count;

  // second instance: narrow counters, Z stuck-at-1
  logic         start2, uut_a2, busy2, done2, vv2;
  logic         uut_z2;
  logic [1:0]   verdict2;
  logic [1:0]   run2, fail2;

  int mode;   // 0 healthy, 1 Z stuck-0, 2 Z stuck-1, 3 buffer
  int checks = 0;
  int errors = 0;

  // reference state
  logic [1:0] exp_verdict;
  logic       exp_vv;
  int         exp_run, exp_fail;

  not_gate_bist_ctrl #(.SETTLE_CYCLES(S), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .uut_a(uut_a), .uut_z(uut_z), .busy(busy), .done(done),
    .verdict(verdict), .verdict_valid(verdict_valid),
    .run_count(run_count), .fail_count(fail_count));

  not_gate_bist_ctrl #(.SETTLE_CYCLES(S), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
    .uut_a(uut_a2), .uut_z(uut_z2), .busy(busy2), .done(done2),
    .verdict(verdict2), .verdict_valid(vv2),
    .run_count(run2), .fail_count(fail2));

  // cell model: what Z does for a given input A in each fault mode
  function automatic logic cell_z(int m, logic a);
    case (m)
      0: return ~a;
      1: return 1'b0;
      2: return 1'b1;
      default: return a;
    endcase
  endfunction

  assign uut_z  = cell_z(mode, uut_a);
  assign uut_z2 = 1'b1;

  // a vector fails when Z differs from the ideal ~A
  function automatic logic [1:0] ref_verdict(int m);
    logic [1:0] v;
    for (int a = 0; a < 2; a++) v[a] = (cell_z(m, a[0]) != ~a[0]);
    return v;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_verdict = 2'b00;
    exp_vv      = 1'b0;
    exp_run     = 0;
    exp_fail    = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_verdict"}, 32'(verdict), 32'(exp_verdict));
    chk({tag, "_vv"}, 32'(verdict_valid), 32'(exp_vv));
    chk({tag, "_run"}, 32'(run_count), 32'(exp_run));
    chk({tag, "_fail"}, 32'(fail_count), 32'(exp_fail));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_a"}, 32'(uut_a), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk_state(tag);
  endtask

  // One run starting now; optional abort / extra start / reset at a given
  // cycle number of the run (cycle 1 = first cycle after start is sampled).
  task automatic run_one(input int m, input int abort_c, input int start_c, input int rst_c);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 2*S+1; c++) begin
      if (c == rst_c) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        chk_reset("midrun_rst");
        return;
      end
      if (c == abort_c) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_a", 32'(uut_a), 0);
        chk_state("abort");
        return;
      end
      chk("run_busy", 32'(busy), 1);
      chk("run_a", 32'(uut_a), 32'(c > S && c <= 2*S));
      chk("run_done", 32'(done), 32'(c == 2*S+1));
      if (c == 2*S+1) begin
        exp_verdict = ref_verdict(m);
        exp_vv      = 1'b1;
        if (exp_run < (1 << W) - 1) exp_run++;
`ifdef NOT_BIST_FAILCNT_EN
        if (exp_verdict != 2'b00 && exp_fail < (1 << W) - 1) exp_fail++;
`endif
        chk_state("report");
      end
      if (c == start_c) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("post_busy", 32'(busy), 0);
    chk("post_done", 32'(done), 0);
    if (start_c > 0) begin
      tick();
      chk("start_not_queued", 32'(busy), 0);
    end
  endtask

  initial begin
    int exp2;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    abort  = 1'b0;
    mode   = 0;
    model_reset();
    tick();
    tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    run_one(0, 0, 0, 0);        // healthy -> 00
    run_one(2, 0, 0, 0);        // Z stuck-1 -> 10
    run_one(1, 0, 0, 0);        // Z stuck-0 -> 01
    run_one(0, 0, 0, 0);        // released -> 00
    run_one(3, 0, 0, 0);        // buffer -> 11
    run_one(0, 0, 0, 0);
    run_one(0, 6, 0, 0);        // abort in APPLY1
    run_one(0, 0, S+2, 0);      // start during APPLY1 ignored

    // start and abort together in IDLE: stay idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 0);
    tick();
    chk("start_abort_idle2", 32'(busy), 0);

    run_one(2, 0, 0, 3);        // reset at cycle 3
    tick();

    for (int i = 0; i < 12; i++) begin
      int m, ab;
      m  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2*S) : 0;
      run_one(m, ab, 0, 0);
    end

    // narrow counters saturate at 3; fifth run still completes on time
    for (int k = 1; k <= 5; k++) begin
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      repeat (2*S - 1) tick();
      chk("sat_done_early", 32'(done2), 0);
      tick();
      chk("sat_done", 32'(done2), 1);
      chk("sat_verdict", 32'(verdict2), 32'h2);
      exp2 = (k > 3) ? 3 : k;
      chk("sat_run", 32'(run2), 32'(exp2));
`ifdef NOT_BIST_FAILCNT_EN
      chk("sat_fail", 32'(fail2), 32'(exp2));
`else
      chk("sat_fail", 32'(fail2), 0);
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
